// File: rtl/mem_stage_if.sv
// Bus between the EX/MEM register and the memory-access stage, plus the MEM/WB outputs.
// The master side is the pipeline/upstream, and the slave side is mem_stage.
interface mem_stage_if;
  logic [63:0] pc_exmem;
  logic [4:0]  rd_exmem;
  logic        branch_exmem;
  logic        Memread_exmem;
  logic        Memwrite_exmem;
  logic        Memtoreg_exmem;
  logic        Regwrite_exmem;
  logic [63:0] alu_result_exmem;
  logic        zero_flag_exmem;
  logic [63:0] readdata2_mem;

  logic        mem_stall;
  logic        pcsrc;
  logic [63:0] branch_target_mem;
  logic [63:0] read_data_memwb;
  logic [63:0] alu_result_memwb;
  logic [4:0]  rd_memwb;
  logic        Regwrite_memwb;
  logic        Memtoreg_memwb;
  logic        mem_err_memwb;

  modport master (
    output pc_exmem, rd_exmem, branch_exmem, Memread_exmem, Memwrite_exmem,
           Memtoreg_exmem, Regwrite_exmem, alu_result_exmem, zero_flag_exmem,
           readdata2_mem,
    input  mem_stall, pcsrc, branch_target_mem, read_data_memwb, alu_result_memwb,
           rd_memwb, Regwrite_memwb, Memtoreg_memwb, mem_err_memwb
  );

  modport slave (
    input  pc_exmem, rd_exmem, branch_exmem, Memread_exmem, Memwrite_exmem,
           Memtoreg_exmem, Regwrite_exmem, alu_result_exmem, zero_flag_exmem,
           readdata2_mem,
    output mem_stall, pcsrc, branch_target_mem, read_data_memwb, alu_result_memwb,
           rd_memwb, Regwrite_memwb, Memtoreg_memwb, mem_err_memwb
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: a multi-cycle doubleword data memory that applies a stall,
// branch resolution, and the MEM/WB register.
module mem_stage #(
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned MEM_LATENCY = 2
) (
  input logic       clk,
  input logic       reset,
  mem_stage_if.slave bus
);

  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned LAT_INIT = (MEM_LATENCY >= 2) ? (MEM_LATENCY - 2) : 0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [63:0]        r_mem [DEPTH];

  logic [63:0]        r_read_data;
  logic [63:0]        r_alu_result;
  logic [4:0]         r_rd;
  logic               r_regwrite;
  logic               r_memtoreg;
  logic               r_mem_err;

  logic               w_req;
  logic               w_is_load;
  logic               w_err;
  logic [60:0]        w_idx_full;
  logic [IDX_W-1:0]   w_idx;
  logic [63:0]        w_load_data;
  logic               w_stall;

  // Decode the access. When both read and write are set, the access is treated as a store
  assign w_req       = bus.Memread_exmem | bus.Memwrite_exmem;
  assign w_is_load   = bus.Memread_exmem & ~bus.Memwrite_exmem;
  assign w_idx_full  = bus.alu_result_exmem[63:3];
  assign w_idx       = w_idx_full[IDX_W-1:0];
  assign w_err       = (|bus.alu_result_exmem[2:0]) | (w_idx_full >= 61'(DEPTH));
  assign w_load_data = (w_is_load & ~w_err) ? r_mem[w_idx] : 64'd0;

  assign w_stall = ~reset & (((r_state == S_IDLE) & w_req) | (r_state == S_WAIT));

  assign bus.mem_stall         = w_stall;
  assign bus.pcsrc             = bus.branch_exmem & bus.zero_flag_exmem & (r_state == S_IDLE) & ~reset;
  assign bus.branch_target_mem = bus.pc_exmem;

  assign bus.read_data_memwb  = r_read_data;
  assign bus.alu_result_memwb = r_alu_result;
  assign bus.rd_memwb         = r_rd;
  assign bus.Regwrite_memwb   = r_regwrite;
  assign bus.Memtoreg_memwb   = r_memtoreg;
  assign bus.mem_err_memwb    = r_mem_err;

  // Access sequencer and MEM/WB register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_read_data  <= '0;
      r_alu_result <= '0;
      r_rd         <= '0;
      r_regwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_mem_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (MEM_LATENCY == 1) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_W'(LAT_INIT);
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) r_state <= S_DONE;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      // A stalled cycle inserts a bubble. Otherwise the op completes this cycle
      if (w_stall) begin
        r_read_data  <= '0;
        r_alu_result <= '0;
        r_rd         <= '0;
        r_regwrite   <= 1'b0;
        r_memtoreg   <= 1'b0;
        r_mem_err    <= 1'b0;
      end else begin
        r_read_data  <= w_load_data;
        r_alu_result <= bus.alu_result_exmem;
        r_rd         <= bus.rd_exmem;
        r_regwrite   <= bus.Regwrite_exmem;
        r_memtoreg   <= bus.Memtoreg_exmem;
        r_mem_err    <= w_req & w_err;
      end
    end
  end

  // Store commits once, at the end of DONE. Reset does not clear the array
  always_ff @(posedge clk) begin
    if (!reset && (r_state == S_DONE) && bus.Memwrite_exmem && !w_err)
      r_mem[w_idx] <= bus.readdata2_mem;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: two instances (latency 2 / depth 128 and latency 1 / depth 16)
// run directed and random ops against a queue-based reference memory model.
module tb_mem_stage;

  localparam int unsigned D0 = 128;
  localparam int unsigned L0 = 2;
  localparam int unsigned D1 = 16;
  localparam int unsigned L1 = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_stage_if if0 ();
  mem_stage_if if1 ();

  mem_stage #(.DEPTH(D0), .MEM_LATENCY(L0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  mem_stage #(.DEPTH(D1), .MEM_LATENCY(L1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  // Driver state; only the selected instance sees active control bits
  logic        sel;
  logic        d_valid;
  logic [63:0] d_pc, d_alu, d_wd;
  logic [4:0]  d_rd;
  logic        d_br, d_zero, d_mr, d_mw, d_mtr, d_rw;
  logic        act0, act1;

  assign act0 = d_valid & ~sel;
  assign act1 = d_valid & sel;

  assign if0.pc_exmem         = d_pc;
  assign if0.rd_exmem         = d_rd;
  assign if0.alu_result_exmem = d_alu;
  assign if0.readdata2_mem    = d_wd;
  assign if0.zero_flag_exmem  = d_zero;
  assign if0.branch_exmem     = d_br  & act0;
  assign if0.Memread_exmem    = d_mr  & act0;
  assign if0.Memwrite_exmem   = d_mw  & act0;
  assign if0.Memtoreg_exmem   = d_mtr & act0;
  assign if0.Regwrite_exmem   = d_rw  & act0;

  assign if1.pc_exmem         = d_pc;
  assign if1.rd_exmem         = d_rd;
  assign if1.alu_result_exmem = d_alu;
  assign if1.readdata2_mem    = d_wd;
  assign if1.zero_flag_exmem  = d_zero;
  assign if1.branch_exmem     = d_br  & act1;
  assign if1.Memread_exmem    = d_mr  & act1;
  assign if1.Memwrite_exmem   = d_mw  & act1;
  assign if1.Memtoreg_exmem   = d_mtr & act1;
  assign if1.Regwrite_exmem   = d_rw  & act1;

  logic        s_stall, s_pcsrc, s_rw, s_mtr, s_err;
  logic [63:0] s_target, s_rdata, s_alu;
  logic [4:0]  s_rd;
  assign s_stall  = sel ? if1.mem_stall         : if0.mem_stall;
  assign s_pcsrc  = sel ? if1.pcsrc             : if0.pcsrc;
  assign s_target = sel ? if1.branch_target_mem : if0.branch_target_mem;
  assign s_rdata  = sel ? if1.read_data_memwb   : if0.read_data_memwb;
  assign s_alu    = sel ? if1.alu_result_memwb  : if0.alu_result_memwb;
  assign s_rd     = sel ? if1.rd_memwb          : if0.rd_memwb;
  assign s_rw     = sel ? if1.Regwrite_memwb    : if0.Regwrite_memwb;
  assign s_mtr    = sel ? if1.Memtoreg_memwb    : if0.Memtoreg_memwb;
  assign s_err    = sel ? if1.mem_err_memwb     : if0.mem_err_memwb;

  typedef struct {
    logic [63:0] rdata;
    logic [63:0] alu;
    logic [4:0]  rd;
    logic        rw;
    logic        mtr;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [63:0] m0 [D0];
  logic [63:0] m1 [D1];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle MEM/WB holds either the op accepted at the last edge or a bubble
  logic acc = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (acc) begin
      if (q.size() == 0) begin
        check("queue_underflow", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check("read_data", s_rdata, e.rdata);
        check("alu_result", s_alu, e.alu);
        check("ctrl_rd_rw_mtr_err", 64'({s_rd, s_rw, s_mtr, s_err}), 64'({e.rd, e.rw, e.mtr, e.err}));
      end
    end else begin
      check("bubble_data", s_rdata | s_alu, 64'd0);
      check("bubble_ctrl", 64'({s_rd, s_rw, s_mtr, s_err}), 64'd0);
    end
    acc = d_valid & ~s_stall & ~reset;
  end

  task automatic clear_drive();
    d_valid = 1'b0; d_br = 1'b0; d_zero = 1'b0; d_mr = 1'b0; d_mw = 1'b0;
    d_mtr = 1'b0; d_rw = 1'b0; d_pc = '0; d_alu = '0; d_wd = '0; d_rd = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one op, predict its MEM/WB result, and check stall length and branch outputs
  task automatic issue(input logic br, input logic zero, input logic mr, input logic mw,
                       input logic mtr, input logic rw, input logic [63:0] pc,
                       input logic [63:0] alu, input logic [63:0] wd, input logic [4:0] rd);
    exp_t        e;
    int unsigned lat, dep;
    logic        req, err;
    logic [60:0] idx;
    int          n;
    lat = sel ? L1 : L0;
    dep = sel ? D1 : D0;
    req = mr | mw;
    idx = alu[63:3];
    err = req && ((alu[2:0] != 3'd0) || (idx >= 61'(dep)));
    e.alu = alu; e.rd = rd; e.rw = rw; e.mtr = mtr; e.err = err; e.rdata = '0;
    if (mr && !mw && !err) e.rdata = sel ? m1[idx[3:0]] : m0[idx[6:0]];
    if (mw && !err) begin
      if (sel) m1[idx[3:0]] = wd;
      else     m0[idx[6:0]] = wd;
    end
    q.push_back(e);
    d_br = br; d_zero = zero; d_mr = mr; d_mw = mw; d_mtr = mtr; d_rw = rw;
    d_pc = pc; d_alu = alu; d_wd = wd; d_rd = rd; d_valid = 1'b1;
    @(negedge clk);
    check("pcsrc", 64'(s_pcsrc), 64'(br & zero));
    check("branch_target", s_target, pc);
    n = 0;
    while (s_stall && n <= 40) begin
      n++;
      @(negedge clk);
    end
    check("stall_cycles", 64'(n), req ? 64'(lat) : 64'd0);
    @(posedge clk); #1;
    clear_drive();
  endtask

  // A store is cut off by reset while in WAIT; it must never reach the array
  task automatic reset_mid_store(input logic [63:0] addr, input logic [63:0] wd);
    d_mw = 1'b1; d_alu = addr; d_wd = wd; d_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("stall_in_reset", 64'(s_stall), 64'd0);
    check("pcsrc_in_reset", 64'(s_pcsrc), 64'd0);
    @(posedge clk); #1;
    clear_drive();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic random_op();
    int unsigned dep, kind;
    logic [63:0] a;
    dep  = sel ? D1 : D0;
    kind = $urandom_range(0, 5);
    a    = 64'($urandom_range(0, dep - 1)) << 3;
    case (kind)
      0: issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, {$urandom, $urandom}, 64'd0, 5'($urandom));
      1: issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'd0, a, 64'd0, 5'($urandom));
      2: issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, a, {$urandom, $urandom}, 5'd0);
      3: begin
        if ($urandom_range(0, 1) == 0) a = a | 64'($urandom_range(1, 7));
        else a = (64'(dep) << 3) + (64'($urandom_range(0, 1000)) << 3);
        issue(1'b0, 1'b0, 1'($urandom), 1'b1, 1'b0, 1'b0, 64'd0, a, {$urandom, $urandom}, 5'd0);
      end
      4: issue(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, a, {$urandom, $urandom}, 5'($urandom));
      default: issue(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, {$urandom, $urandom},
                     {$urandom, $urandom}, 64'd0, 5'd0);
    endcase
  endtask

  initial begin
    reset = 1'b1;
    sel   = 1'b0;
    clear_drive();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < int'(D0); i++)
      issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'(i) << 3, {$urandom, $urandom}, 5'd0);

    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 64'h2A, 64'd0, 5'd5);
    issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'h40, 64'hDEADBEEF_CAFEF00D, 5'd0);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'd0, 64'h40, 64'd0, 5'd7);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'd0, 64'h43, 64'd0, 5'd3);
    issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'(D0) * 64'd8, 64'h1234_5678_9ABC_DEF0, 5'd0);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'd0, 64'h0, 64'd0, 5'd9);
    issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h100, 64'd0, 64'd0, 5'd0);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h100, 64'd1, 64'd0, 5'd0);

    idle(2);
    reset_mid_store(64'h80, 64'hBAD0_BAD0_BAD0_BAD0);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'd0, 64'h80, 64'd0, 5'd11);

    for (int i = 0; i < 200; i++) random_op();

    idle(3);
    sel = 1'b1;
    idle(2);
    for (int i = 0; i < int'(D1); i++)
      issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'(i) << 3, {$urandom, $urandom}, 5'd0);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'd0, 64'h10, 64'd0, 5'd4);
    issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'(D1) * 64'd8, 64'hFFFF_0000_FFFF_0000, 5'd0);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'd0, 64'h0, 64'd0, 5'd6);
    for (int i = 0; i < 100; i++) random_op();

    idle(3);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
